data_store_buffer: RTL
======================

Name: data_store_buffer

Overview:
- Sits directly downstream of the single-cycle datapath, between its memory outputs (ALUOut address, WriteData) and the slow external data memory port.
- Stores are absorbed into a FIFO in one cycle and drained to memory in the background.
- Loads hit the buffer with zero latency (store-to-load forwarding). On a miss, the block drains the buffer and then performs an external read.
- Stall feeds the top-level clock-enable of the PC register and the register-file write enable.

Parameters:
DEPTH, 4, number of buffered store entries (power of 2, >=2)
WIDTH, 32, data/address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
MemWrite  input  1  core store request this cycle
MemRead  input  1  core load request this cycle
ALUOut  input  WIDTH  byte address from datapath; bits [1:0] ignored
WriteData  input  WIDTH  store data
ReadData  output  WIDTH  load data to datapath result mux
Stall  output  1  core must hold state and inputs this cycle
mem_req  output  1  external request valid
mem_we  output  1  1 = write, 0 = read (valid with mem_req)
mem_addr  output  WIDTH  word address {addr[31:2],2'b00}
mem_wdata  output  WIDTH  write data
mem_rdata  input  WIDTH  read data, valid with mem_ack on a read
mem_ack  input  1  external completes current request at this edge

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO empty, count=0, FSM=IDLE, captured read data = 0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Stall=0, ReadData=0.
  - Any external transaction in flight is abandoned.
- FIFO:
  - Circular buffer of {word_addr, data}. Head/tail pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Store enqueue:
  - Condition: MemWrite=1 and count<DEPTH at the cycle start. Entry is written at the edge and Stall=0.
  - If count==DEPTH: Stall=1 combinationally and nothing is enqueued. The core retries every cycle.
  - A pop in the same cycle does not free space until the next cycle.
- Drain:
  - In IDLE or LOAD_DRAIN with count>0: mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry.
  - Values are held stable until mem_ack. On the ack edge the head pops.
  - mem_ack in the same cycle as a new mem_req is legal.
  - Enqueue and pop in the same cycle: count unchanged.
- Load hit:
  - Condition: MemRead=1 in IDLE and any valid entry matches ALUOut[31:2].
  - ReadData = data of the newest matching entry (closest to tail). Stall=0. Zero latency, combinational.
- Load miss, in IDLE:
  - Stall=1 and the FSM moves to LOAD_DRAIN.
- LOAD_DRAIN:
  - Stall=1. Draining continues.
  - When count==0 (including the edge where the last entry pops), go to LOAD_REQ.
- LOAD_REQ:
  - Stall=1. mem_req=1, mem_we=0, mem_addr = word of the held ALUOut.
  - On mem_ack: capture mem_rdata and go to LOAD_DONE.
- LOAD_DONE:
  - Stall=0 and ReadData = captured data. The core completes the load at this edge.
  - Next state is IDLE. mem_req=0 in this state.
- Other ReadData rules:
  - ReadData=0 whenever MemRead=0.
  - During stalled load states ReadData = captured data (don't-care to the core).
- Core obligation: while Stall=1, the core holds MemRead, MemWrite, ALUOut and WriteData stable.
- MemRead and MemWrite both 1: treated as a store only.
- Ordering: loads never read external memory while older stores are pending, so the buffer plus memory always presents program-order data.

Test Plan:
- Reset mid-drain: 2 stores queued, mem_req=1 with no ack, assert rst -> mem_req=0, Stall=0 and count=0 immediately, asynchronously before the next edge.
- Store then load same word: store 0x100←0xDEADBEEF, next cycle load 0x103 with ack held low -> ReadData=0xDEADBEEF, Stall=0, no mem_req with mem_we=0.
- Newest-match forwarding: stores 0x40←1, 0x40←2, load 0x40 -> ReadData=2.
- Full buffer: ack held low, 4 stores accepted, 5th store -> Stall=1. Then one mem_ack -> 5th store accepted the following cycle with Stall=0. Final drain order on mem_wdata is 1..5.
- Load miss with pending stores: 2 stores queued, load 0x200:
  - Stall=1 through both write acks, then a read req at 0x200.
  - mem_rdata=0x12345678 with ack -> LOAD_DONE cycle shows Stall=0 and ReadData=0x12345678.
- Same-cycle ack: mem_ack tied high, stream 8 back-to-back stores -> each drains in 1 cycle, Stall stays 0, mem_addr/mem_wdata sequence matches the stores in order.

Source files
------------

// File: rtl/data_store_buffer.sv
// Store buffer between the core and slow data memory: stores retire in one cycle, loads forward
// from the newest matching entry, and a load miss drains every pending store before reading.
module data_store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = WIDTH - 2;

  typedef enum logic [1:0] {IDLE, LOAD_DRAIN, LOAD_REQ, LOAD_DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    fifo_addr [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [PW-1:0]    head, tail, idx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    load_addr;
  logic             is_load, full, empty, drain, push, pop, hit;
  logic [WIDTH-1:0] hit_data;
  logic             unused_lsb;

  assign unused_lsb = ^ALUOut[1:0];
  assign is_load    = MemRead & ~MemWrite;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign drain      = ((state == IDLE) || (state == LOAD_DRAIN)) && !empty;
  assign push       = MemWrite && !full;
  assign pop        = drain && mem_ack;

  // Walk from oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (fifo_addr[idx] == ALUOut[WIDTH-1:2])) begin
        hit      = 1'b1;
        hit_data = fifo_data[idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ReadData  = '0;
    if (drain) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {fifo_addr[head], 2'b00};
      mem_wdata = fifo_data[head];
    end
    case (state)
      IDLE: begin
        if (MemWrite && full) begin
          Stall = 1'b1;
        end else if (is_load && !hit) begin
          Stall     = 1'b1;
          state_nxt = LOAD_DRAIN;
        end
      end
      LOAD_DRAIN: begin
        Stall = 1'b1;
        if (empty || ((count == CW'(1)) && pop)) state_nxt = LOAD_REQ;
      end
      LOAD_REQ: begin
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {load_addr, 2'b00};
        if (mem_ack) state_nxt = LOAD_DONE;
      end
      LOAD_DONE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (MemRead) ReadData = ((state == IDLE) && is_load && hit) ? hit_data : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rdata_q   <= '0;
      load_addr <= '0;
    end else begin
      state <= state_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if ((state == LOAD_REQ) && mem_ack) rdata_q <= mem_rdata;
      if ((state == IDLE) && is_load && !hit) load_addr <= ALUOut[WIDTH-1:2];
    end
  end

  // Storage needs no reset: entries beyond count are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= ALUOut[WIDTH-1:2];
      fifo_data[tail] <= WriteData;
    end
  end
endmodule
